lif_ctrl_sequencer: RTL and testbench
=====================================

Name: lif_ctrl_sequencer

Overview:
- Controller that sits in front of the LIF neuron `top`.
- Accepts a parallel configuration word (decay, weight, threshold) over a valid/ready handshake and shifts it into the neuron serially on `set_vars`/`expd`/`w`/`t`.
- Shares the neuron's single `syn` input among N_SRC spike requesters with a round-robin arbiter and a minimum inter-spike gap.
- Counts output spikes seen on `axon`.

Parameters:
- WIDTH, 8, bits per configuration field; also the number of serial load cycles.
- N_SRC, 4, number of spike requesters (2..8).
- MIN_GAP, 2, minimum cycles between successive syn pulses (>=2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_valid  input  1  configuration word offered.
- cfg_ready  output  1  configuration word accepted when cfg_valid & cfg_ready.
- cfg_expd  input  WIDTH  decay value.
- cfg_w  input  WIDTH  synaptic weight.
- cfg_t  input  WIDTH  firing threshold.
- spk_req  input  N_SRC  per-source spike request, level; held until granted.
- spk_grant  output  N_SRC  one-hot grant, one-cycle pulse.
- set_vars  output  1  serial-load enable to neuron.
- expd  output  1  serial decay bit.
- w  output  1  serial weight bit.
- t  output  1  serial threshold bit.
- syn  output  1  synaptic input pulse to neuron.
- axon  input  1  neuron spike output.
- spike_count  output  16  rising edges of axon counted in RUN.
- busy  output  1  high while in LOAD.

Behaviour:
- Reset (rst high at an edge):
  - state=IDLE; rr pointer=0; gap counter=0; spike_count=0.
  - set_vars, expd, w, t, syn, spk_grant and busy all 0.
  - cfg_ready is 0 while rst is high.
- All outputs except cfg_ready are registered. cfg_ready = !rst & (state==IDLE | state==RUN).
- States:
  - IDLE: no grants. cfg handshake -> LOAD.
  - LOAD: lasts exactly WIDTH cycles, then -> RUN. busy=1, cfg_ready=0, syn=0, no grants.
  - RUN: arbitration active. cfg handshake -> LOAD (reconfiguration).
- Handshake and capture:
  - On a handshake edge, all three fields are latched into shift registers.
  - On the same edge, spike_count clears to 0 and the axon edge detector's previous-value register clears to 0.
- Serial load:
  - In load cycle i (i=0..WIDTH-1, first cycle directly after the handshake edge): set_vars=1, expd=cfg_expd[WIDTH-1-i], w=cfg_w[WIDTH-1-i], t=cfg_t[WIDTH-1-i] (MSB first).
  - In the cycle after the last bit: set_vars=0, expd=w=t=0, and the state is RUN.
- Arbitration (RUN only):
  - A decision edge is any RUN edge where the gap counter is 0, no cfg handshake occurs, and spk_req != 0.
  - The winner is the first set bit searching upward from the rr pointer, wrapping modulo N_SRC.
  - In the next cycle, spk_grant = one-hot(winner) and syn=1 for exactly one cycle. rr pointer = (winner+1) mod N_SRC.
  - Gap counter is loaded with MIN_GAP-1 and decrements every cycle to 0. The next grant is therefore at the earliest MIN_GAP cycles after the previous one.
  - A requester drops its req on the edge ending its grant cycle, so it is never granted twice for one request.
- Simultaneous events:
  - cfg handshake and a pending request on the same RUN edge: the cfg wins, no grant is issued, and the request stays pending until after the load.
  - A grant already registered before a handshake edge is still output; syn then goes low in the first LOAD cycle.
  - Reconfiguration resets the gap counter to 0. The rr pointer is kept.
- spike_count:
  - In RUN, increments on each cycle where axon=1 and the previous axon sample was 0.
  - Saturates at 16'hFFFF; does not count in IDLE or LOAD.
- Reset mid-LOAD: load aborts, outputs return to reset values, and the neuron receives a partial load. The requester must re-send the configuration.

Test Plan:
1. Reset, then handshake with cfg_expd=8'hA5, cfg_w=8'h3C, cfg_t=8'hF0.
   - set_vars=1 for exactly 8 cycles.
   - expd sequence 1,0,1,0,0,1,0,1; w sequence 0,0,1,1,1,1,0,0; t sequence 1,1,1,1,0,0,0,0.
   - busy=1 over the same 8 cycles, then RUN with all serial outputs 0.
2. RUN, spk_req=4'b1111 held (each source drops after its grant).
   - Grants 0001, 0010, 0100, 1000 in order, exactly 2 cycles apart.
   - syn=1 on each grant cycle, 0 between.
3. RUN with MIN_GAP=3, single source req=4'b0100 re-raised immediately after each grant.
   - Grants separated by exactly 3 cycles; never in adjacent cycles.
4. RUN, req=4'b0001 and cfg_valid both rise on the same edge.
   - No grant; 8-cycle LOAD runs.
   - Grant 0001 appears in the first eligible RUN cycle after the load.
5. Axon pattern 0,1,1,0,1,0,1 in RUN gives spike_count=3. Then a new cfg handshake clears it to 0, and axon pulses during LOAD are not counted.
6. rst asserted on load cycle 4.
   - Next cycle all outputs are 0 and state is IDLE.
   - cfg_ready=1 once rst deasserts.
   - A fresh load completes normally.

Source files
------------

// File: rtl/lif_ctrl_sequencer.sv
// Front-end controller for the LIF neuron: serial configuration loader,
// round-robin spike arbiter with a minimum inter-pulse gap, and an axon
// spike counter.
module lif_ctrl_sequencer #(
    parameter int WIDTH   = 8,
    parameter int N_SRC   = 4,
    parameter int MIN_GAP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_expd,
    input  logic [WIDTH-1:0] cfg_w,
    input  logic [WIDTH-1:0] cfg_t,
    input  logic [N_SRC-1:0] spk_req,
    output logic [N_SRC-1:0] spk_grant,
    output logic             set_vars,
    output logic             expd,
    output logic             w,
    output logic             t,
    output logic             syn,
    input  logic             axon,
    output logic [15:0]      spike_count,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = $clog2(N_SRC);
    localparam int GW = $clog2(MIN_GAP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [CW-1:0]      load_cnt_r, load_cnt_s;
    logic [WIDTH-1:0]   sh_expd_r, sh_expd_s;
    logic [WIDTH-1:0]   sh_w_r, sh_w_s;
    logic [WIDTH-1:0]   sh_t_r, sh_t_s;
    logic               set_vars_r, set_vars_s;
    logic               expd_r, expd_s;
    logic               w_r, w_s;
    logic               t_r, t_s;
    logic               syn_r, syn_s;
    logic               busy_r, busy_s;
    logic [N_SRC-1:0]   grant_r, grant_s;
    logic [PW-1:0]      rr_r, rr_s;
    logic [GW-1:0]      gap_r, gap_s;
    logic [15:0]        count_r, count_s;
    logic               axon_prev_r, axon_prev_s;

    logic               cfg_hs_s;
    logic               found_s;
    logic [PW-1:0]      win_s;
    logic [PW:0]        sum_s;

    // cfg_ready is the only combinational output; it must drop while rst is high.
    assign cfg_ready = !rst && ((state_r == ST_IDLE) || (state_r == ST_RUN));
    assign cfg_hs_s  = cfg_valid && cfg_ready;

    assign spk_grant   = grant_r;
    assign set_vars    = set_vars_r;
    assign expd        = expd_r;
    assign w           = w_r;
    assign t           = t_r;
    assign syn         = syn_r;
    assign busy        = busy_r;
    assign spike_count = count_r;

    // Round-robin search: first requesting source at or above the pointer, wrapping.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        sum_s   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            sum_s = {1'b0, rr_r} + (PW+1)'(k);
            if (sum_s >= (PW+1)'(N_SRC)) begin
                sum_s = sum_s - (PW+1)'(N_SRC);
            end else begin
                sum_s = sum_s;
            end
            if (!found_s && spk_req[sum_s[PW-1:0]]) begin
                found_s = 1'b1;
                win_s   = sum_s[PW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and next-output logic; a handshake overrides everything else.
    always_comb begin
        state_s     = state_r;
        load_cnt_s  = load_cnt_r;
        sh_expd_s   = sh_expd_r;
        sh_w_s      = sh_w_r;
        sh_t_s      = sh_t_r;
        set_vars_s  = 1'b0;
        expd_s      = 1'b0;
        w_s         = 1'b0;
        t_s         = 1'b0;
        syn_s       = 1'b0;
        busy_s      = 1'b0;
        grant_s     = '0;
        rr_s        = rr_r;
        gap_s       = (gap_r != '0) ? (gap_r - GW'(1)) : gap_r;
        count_s     = count_r;
        axon_prev_s = axon;

        if (cfg_hs_s) begin
            // Capture the word and present the MSBs in the very next cycle.
            state_s     = ST_LOAD;
            load_cnt_s  = '0;
            set_vars_s  = 1'b1;
            busy_s      = 1'b1;
            expd_s      = cfg_expd[WIDTH-1];
            w_s         = cfg_w[WIDTH-1];
            t_s         = cfg_t[WIDTH-1];
            sh_expd_s   = {cfg_expd[WIDTH-2:0], 1'b0};
            sh_w_s      = {cfg_w[WIDTH-2:0], 1'b0};
            sh_t_s      = {cfg_t[WIDTH-2:0], 1'b0};
            gap_s       = '0;
            count_s     = 16'd0;
            axon_prev_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_LOAD: begin
                    if (load_cnt_r == CW'(WIDTH-1)) begin
                        state_s = ST_RUN;
                    end else begin
                        load_cnt_s = load_cnt_r + CW'(1);
                        set_vars_s = 1'b1;
                        busy_s     = 1'b1;
                        expd_s     = sh_expd_r[WIDTH-1];
                        w_s        = sh_w_r[WIDTH-1];
                        t_s        = sh_t_r[WIDTH-1];
                        sh_expd_s  = {sh_expd_r[WIDTH-2:0], 1'b0};
                        sh_w_s     = {sh_w_r[WIDTH-2:0], 1'b0};
                        sh_t_s     = {sh_t_r[WIDTH-2:0], 1'b0};
                    end
                end
                ST_RUN: begin
                    if ((gap_r == '0) && found_s) begin
                        grant_s = {{(N_SRC-1){1'b0}}, 1'b1} << win_s;
                        syn_s   = 1'b1;
                        gap_s   = GW'(MIN_GAP-1);
                        if (win_s == PW'(N_SRC-1)) begin
                            rr_s = '0;
                        end else begin
                            rr_s = win_s + PW'(1);
                        end
                    end else begin
                        grant_s = '0;
                    end
                    if (axon && !axon_prev_r && (count_r != 16'hFFFF)) begin
                        count_s = count_r + 16'd1;
                    end else begin
                        count_s = count_r;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            load_cnt_r  <= '0;
            sh_expd_r   <= '0;
            sh_w_r      <= '0;
            sh_t_r      <= '0;
            set_vars_r  <= 1'b0;
            expd_r      <= 1'b0;
            w_r         <= 1'b0;
            t_r         <= 1'b0;
            syn_r       <= 1'b0;
            busy_r      <= 1'b0;
            grant_r     <= '0;
            rr_r        <= '0;
            gap_r       <= '0;
            count_r     <= 16'd0;
            axon_prev_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            load_cnt_r  <= load_cnt_s;
            sh_expd_r   <= sh_expd_s;
            sh_w_r      <= sh_w_s;
            sh_t_r      <= sh_t_s;
            set_vars_r  <= set_vars_s;
            expd_r      <= expd_s;
            w_r         <= w_s;
            t_r         <= t_s;
            syn_r       <= syn_s;
            busy_r      <= busy_s;
            grant_r     <= grant_s;
            rr_r        <= rr_s;
            gap_r       <= gap_s;
            count_r     <= count_s;
            axon_prev_r <= axon_prev_s;
        end
    end

endmodule

// File: tb/tb_lif_ctrl_sequencer.sv
// Scoreboard bench for lif_ctrl_sequencer: expected serial bits and grants
// are queued by the stimulus and popped by monitors at the falling edge.
module tb_lif_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid, cfg_valid3;
    logic       cfg_ready, cfg_ready3;
    logic [7:0] cfg_expd, cfg_w, cfg_t;
    logic [3:0] spk_req, spk_req3;
    logic [3:0] spk_grant, spk_grant3;
    logic       set_vars, expd, w, t, syn, busy;
    logic       set_vars3, expd3, w3, t3, syn3, busy3;
    logic       axon;
    logic [15:0] spike_count, spike_count3;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rearm3 = 0;

    typedef struct packed {
        int         c;
        logic [3:0] g;
    } gexp_t;

    gexp_t      gq[$];
    gexp_t      g3q[$];
    logic [2:0] lq[$];

    lif_ctrl_sequencer #(.WIDTH(8), .N_SRC(4), .MIN_GAP(2)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_expd(cfg_expd), .cfg_w(cfg_w), .cfg_t(cfg_t),
        .spk_req(spk_req), .spk_grant(spk_grant), .set_vars(set_vars),
        .expd(expd), .w(w), .t(t), .syn(syn), .axon(axon),
        .spike_count(spike_count), .busy(busy)
    );

    lif_ctrl_sequencer #(.WIDTH(8), .N_SRC(4), .MIN_GAP(3)) dut3 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
        .cfg_expd(cfg_expd), .cfg_w(cfg_w), .cfg_t(cfg_t),
        .spk_req(spk_req3), .spk_grant(spk_grant3), .set_vars(set_vars3),
        .expd(expd3), .w(w3), .t(t3), .syn(syn3), .axon(1'b0),
        .spike_count(spike_count3), .busy(busy3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Monitor for the MIN_GAP=2 instance: serial bits and grants.
    always @(negedge clk) begin
        if (set_vars === 1'b1) begin
            if (lq.size() == 0) begin
                checks++; errors++;
                $display("FAIL serial_unexpected: got set_vars=1 expected 0 (cycle %0d)", cyc);
            end else begin
                check("serial_bits", {29'd0, expd, w, t}, {29'd0, lq.pop_front()});
            end
        end
        if (spk_grant !== 4'b0000) begin
            if (gq.size() == 0) begin
                checks++; errors++;
                $display("FAIL grant_unexpected: got %b expected none (cycle %0d)", spk_grant, cyc);
            end else begin
                gexp_t e;
                e = gq.pop_front();
                check("grant_value", {28'd0, spk_grant}, {28'd0, e.g});
                check("grant_cycle", cyc, e.c);
            end
            check("syn_on_grant", {31'd0, syn}, 32'd1);
        end else begin
            check("syn_idle", {31'd0, syn}, 32'd0);
        end
    end

    // Monitor for the MIN_GAP=3 instance: grants only.
    always @(negedge clk) begin
        if (spk_grant3 !== 4'b0000) begin
            if (g3q.size() == 0) begin
                checks++; errors++;
                $display("FAIL grant3_unexpected: got %b expected none (cycle %0d)", spk_grant3, cyc);
            end else begin
                gexp_t e;
                e = g3q.pop_front();
                check("grant3_value", {28'd0, spk_grant3}, {28'd0, e.g});
                check("grant3_cycle", cyc, e.c);
            end
        end
    end

    // Advance one cycle; requesters drop a request on the edge ending its grant.
    task automatic step();
        logic [3:0] g1, g3;
        g1 = spk_grant;
        g3 = spk_grant3;
        @(posedge clk);
        #1;
        spk_req  = spk_req & ~g1;
        spk_req3 = spk_req3 & ~g3;
        if (g3 != 4'b0000 && rearm3 > 0) begin
            spk_req3 = spk_req3 | g3;
            rearm3--;
        end
    endtask

    task automatic do_cfg(input logic [7:0] e, input logic [7:0] wv, input logic [7:0] tv);
        cfg_expd  = e;
        cfg_w     = wv;
        cfg_t     = tv;
        cfg_valid = 1'b1;
        for (int i = 0; i < 8; i++) lq.push_back({e[7-i], wv[7-i], tv[7-i]});
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] axon_pat);
        for (int i = 0; i < 8; i++) begin
            check("busy_load", {31'd0, busy}, 32'd1);
            check("set_vars_load", {31'd0, set_vars}, 32'd1);
            axon = axon_pat[i];
            step();
        end
        axon = 1'b0;
        check("busy_after", {31'd0, busy}, 32'd0);
        check("set_vars_after", {31'd0, set_vars}, 32'd0);
        check("serial_zero", {29'd0, expd, w, t}, 32'd0);
        check("ready_run", {31'd0, cfg_ready}, 32'd1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 40 && (gq.size() != 0 || g3q.size() != 0); k++) step();
        checks++;
        if (gq.size() != 0 || g3q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0", gq.size(), g3q.size());
        end
    endtask

    initial begin
        int n;
        logic [6:0] apat;
        rst = 1'b1; cfg_valid = 1'b0; cfg_valid3 = 1'b0;
        cfg_expd = 8'h00; cfg_w = 8'h00; cfg_t = 8'h00;
        spk_req = 4'b0000; spk_req3 = 4'b0000; axon = 1'b0;
        step(); step();

        // Reset state
        check("rst_outputs", {26'd0, spk_grant, set_vars, busy}, 32'd0);
        check("rst_serial", {28'd0, expd, w, t, syn}, 32'd0);
        check("rst_count", {16'd0, spike_count}, 32'd0);
        check("rst_ready", {31'd0, cfg_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_ready", {31'd0, cfg_ready}, 32'd1);

        // Test 1: serial load of A5/3C/F0 (second instance configured alongside)
        cfg_valid3 = 1'b1;
        do_cfg(8'hA5, 8'h3C, 8'hF0);
        cfg_valid3 = 1'b0;
        run_load(8'h00);

        // Test 2: all four sources, grants 2 cycles apart
        n = cyc;
        spk_req = 4'b1111;
        gq.push_back('{c: n + 1, g: 4'b0001});
        gq.push_back('{c: n + 3, g: 4'b0010});
        gq.push_back('{c: n + 5, g: 4'b0100});
        gq.push_back('{c: n + 7, g: 4'b1000});
        wait_drain();

        // Test 3: MIN_GAP=3, single source re-raised after each grant
        n = cyc;
        spk_req3 = 4'b0100;
        rearm3 = 3;
        g3q.push_back('{c: n + 1,  g: 4'b0100});
        g3q.push_back('{c: n + 4,  g: 4'b0100});
        g3q.push_back('{c: n + 7,  g: 4'b0100});
        g3q.push_back('{c: n + 10, g: 4'b0100});
        wait_drain();

        // Test 4: request and handshake on the same edge; cfg wins
        n = cyc;
        spk_req = 4'b0001;
        gq.push_back('{c: n + 10, g: 4'b0001});
        do_cfg(8'h5A, 8'hC3, 8'h0F);
        run_load(8'h00);
        wait_drain();

        // Test 5: axon 0,1,1,0,1,0,1 -> 3 rising edges
        apat = 7'b1010110;
        for (int i = 0; i < 7; i++) begin
            axon = apat[i];
            step();
        end
        axon = 1'b0;
        step();
        check("count_three", {16'd0, spike_count}, 32'd3);
        do_cfg(8'h11, 8'h22, 8'h44);
        check("count_clear", {16'd0, spike_count}, 32'd0);
        run_load(8'b00101010);
        check("count_load_ignored", {16'd0, spike_count}, 32'd0);
        axon = 1'b1;
        step();
        axon = 1'b0;
        step();
        check("count_after_load", {16'd0, spike_count}, 32'd1);

        // Test 6: reset on load cycle 4, then a fresh load
        do_cfg(8'hC3, 8'h81, 8'h7E);
        step(); step(); step(); step();
        rst = 1'b1;
        #1;
        check("ready_in_rst", {31'd0, cfg_ready}, 32'd0);
        step();
        lq.delete();
        check("rst_mid_outputs", {26'd0, spk_grant, set_vars, busy}, 32'd0);
        check("rst_mid_serial", {28'd0, expd, w, t, syn}, 32'd0);
        check("rst_mid_count", {16'd0, spike_count}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, cfg_ready}, 32'd1);
        do_cfg(8'h96, 8'h0F, 8'hE1);
        run_load(8'h00);

        // Pointer was reset to 0: source 0 wins before source 1
        n = cyc;
        spk_req = 4'b0011;
        gq.push_back('{c: n + 1, g: 4'b0001});
        gq.push_back('{c: n + 3, g: 4'b0010});
        wait_drain();
        step(); step();
        check("load_queue_empty", lq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
